gate_pipe: RTL

GATE_PIPE -- requirements
Module: gate_pipe

---
 rtl/gate_pipe.sv | 96 +++++++++
 1 files changed

// File: rtl/gate_pipe.sv
// Two-stage valid/ready pipeline that applies a bitwise gate op to a and b.
// It also produces reduction flags of the result and a count of output handshakes.
module gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             red_and,
    output logic             red_or,
    output logic             red_xor,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int STAGES = 2;

    // r_vld_pipe[1] is the S1 valid bit, r_vld_pipe[2] is the S2 valid bit.
    logic [STAGES:1]  r_vld_pipe;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_y;
    logic             r_red_and;
    logic             r_red_or;
    logic             r_red_xor;
    logic [CNT_W-1:0] r_cnt;

    logic             w_adv;
    logic             w_out_xfer;
    logic [WIDTH-1:0] w_y;

    // A stage advances whenever S2 is empty or its result is being taken.
    assign w_adv      = !r_vld_pipe[2] || out_ready;
    assign w_out_xfer = r_vld_pipe[2] && out_ready;

    always_comb begin
        w_y = '0;
        case (r_op)
            3'd0:    w_y = r_a & r_b;
            3'd1:    w_y = r_a | r_b;
            3'd2:    w_y = r_a ^ r_b;
            3'd3:    w_y = ~(r_a & r_b);
            3'd4:    w_y = ~(r_a | r_b);
            3'd5:    w_y = ~(r_a ^ r_b);
            3'd6:    w_y = r_a;
            default: w_y = ~r_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_y        <= '0;
            r_red_and  <= 1'b0;
            r_red_or   <= 1'b0;
            r_red_xor  <= 1'b0;
        end else if (w_adv) begin
            r_vld_pipe <= {r_vld_pipe[1], in_valid};
            r_a        <= a;
            r_b        <= b;
            r_op       <= op;
            // Flags come from the same combinational y that is being registered.
            r_y        <= w_y;
            r_red_and  <= &w_y;
            r_red_or   <= |w_y;
            r_red_xor  <= ^w_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_out_xfer)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign in_ready  = w_adv;
    assign out_valid = r_vld_pipe[2];
    assign y         = r_y;
    assign red_and   = r_red_and;
    assign red_or    = r_red_or;
    assign red_xor   = r_red_xor;
    assign xfer_cnt  = r_cnt;

endmodule
